// File: rtl/nioslab2_onchip_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nioslab2_onchip_ram_arbiter
// Brief    : Two-requester round-robin arbiter in front of a single-port
//            on-chip RAM with registered address and one-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
module nioslab2_onchip_ram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RDATA = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last_grant;
    logic              r_winner;
    logic [ADDR_W-1:0] r_ram_address;
    logic [BE_W-1:0]   r_ram_byteenable;
    logic [DATA_W-1:0] r_ram_writedata;
    logic              r_ram_chipselect;
    logic              r_ram_write;
    logic              r_m0_waitrequest;
    logic              r_m1_waitrequest;
    logic              r_m0_readdatavalid;
    logic              r_m1_readdatavalid;

    logic              w_m0_pending;
    logic              w_m1_pending;
    logic              w_grant;
    logic [ADDR_W-1:0] w_sel_address;
    logic [BE_W-1:0]   w_sel_byteenable;
    logic [DATA_W-1:0] w_sel_writedata;
    logic              w_sel_write;

    assign w_m0_pending = m0_read | m0_write;
    assign w_m1_pending = m1_read | m1_write;

    // On a tie the requester that did not win last time goes next.
    assign w_grant = (w_m0_pending && w_m1_pending) ? ~r_last_grant : w_m1_pending;

    assign w_sel_address    = w_grant ? m1_address    : m0_address;
    assign w_sel_byteenable = w_grant ? m1_byteenable : m0_byteenable;
    assign w_sel_writedata  = w_grant ? m1_writedata  : m0_writedata;
    assign w_sel_write      = w_grant ? m1_write      : m0_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_last_grant       <= 1'b1;
            r_winner           <= 1'b0;
            r_ram_address      <= '0;
            r_ram_byteenable   <= '0;
            r_ram_writedata    <= '0;
            r_ram_chipselect   <= 1'b0;
            r_ram_write        <= 1'b0;
            r_m0_waitrequest   <= 1'b1;
            r_m1_waitrequest   <= 1'b1;
            r_m0_readdatavalid <= 1'b0;
            r_m1_readdatavalid <= 1'b0;
        end else begin
            r_ram_chipselect   <= 1'b0;
            r_ram_write        <= 1'b0;
            r_m0_waitrequest   <= 1'b1;
            r_m1_waitrequest   <= 1'b1;
            r_m0_readdatavalid <= 1'b0;
            r_m1_readdatavalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_m0_pending || w_m1_pending) begin
                        r_winner         <= w_grant;
                        r_last_grant     <= w_grant;
                        r_ram_address    <= w_sel_address;
                        r_ram_byteenable <= w_sel_byteenable;
                        r_ram_writedata  <= w_sel_writedata;
                        r_ram_chipselect <= 1'b1;
                        r_ram_write      <= w_sel_write;
                        if (w_grant) begin
                            r_m1_waitrequest <= 1'b0;
                        end else begin
                            r_m0_waitrequest <= 1'b0;
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_ram_write) begin
                        r_state <= ST_IDLE;
                    end else begin
                        if (r_winner) begin
                            r_m1_readdatavalid <= 1'b1;
                        end else begin
                            r_m0_readdatavalid <= 1'b1;
                        end
                        r_state <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_address    = r_ram_address;
    assign ram_byteenable = r_ram_byteenable;
    assign ram_writedata  = r_ram_writedata;
    assign ram_chipselect = r_ram_chipselect;
    assign ram_write      = r_ram_write;
    assign ram_clken      = ~reset;

    assign m0_waitrequest = r_m0_waitrequest;
    assign m1_waitrequest = r_m1_waitrequest;

    // Reset arriving during the return cycle suppresses the strobe immediately.
    assign m0_readdatavalid = r_m0_readdatavalid & ~reset;
    assign m1_readdatavalid = r_m1_readdatavalid & ~reset;

    assign m0_readdata = ram_readdata;
    assign m1_readdata = ram_readdata;

endmodule
`default_nettype wire

// File: doc/nioslab2_onchip_ram_arbiter.md
NIOSLAB2_ONCHIP_RAM_ARBITER -- requirements
Module: niosLab2_onchip_ram_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 13, word-address width.
- DATA_W, default 32, data width.
- BE_W, default 4, byteenable width (DATA_W/8).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic rising-edge.
- reset, in, 1, synchronous, active-high.
- mN_address, in, ADDR_W, requester N word address (N = 0,1, likewise for the ports below).
- mN_byteenable, in, BE_W, requester N byte lanes.
- mN_read, in, 1, requester N read command.
- mN_write, in, 1, requester N write command.
- mN_writedata, in, DATA_W, requester N write data.
- mN_waitrequest, out, 1, high = command not accepted.
- mN_readdata, out, DATA_W, read return data.
- mN_readdatavalid, out, 1, one-cycle read-return strobe.
- ram_address, out, ADDR_W, to RAM address.
- ram_byteenable, out, BE_W, to RAM byteenable.
- ram_chipselect, out, 1, to RAM chipselect.
- ram_write, out, 1, to RAM write.
- ram_writedata, out, DATA_W, to RAM writedata.
- ram_clken, out, 1, to RAM clken.
- ram_readdata, in, DATA_W, from RAM; valid the cycle after the RAM samples a read address (registered address, unregistered output).

REQ-003 Clock and reset are one clock named clk and a synchronous, active-high reset named reset.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, RDATA; one access in flight at most.
REQ-005 A requester is "pending" when mN_read | mN_write is high.
REQ-006 IDLE:
- No requester pending: stay in IDLE.
- Otherwise: select a winner, register the winner's address, byteenable, writedata and write (write = mN_write) into the ram_* outputs, then go to ISSUE.
REQ-007 Winner selection SHALL be round-robin:
- Only one requester pending: that requester wins.
- Both pending: the requester not granted last wins.
- last_grant SHALL update on every grant.
REQ-008 ISSUE:
- ram_chipselect = 1 and winner's mN_waitrequest = 0 for exactly this cycle.
- Next state: IDLE if it was a write, RDATA if it was a read.
REQ-009 RDATA:
- Winner's mN_readdatavalid = 1 for exactly this cycle.
- mN_readdata carries ram_readdata.
- Next state: IDLE.
REQ-010 Latency and throughput:
- Write accepted 1 cycle after first pending cycle in IDLE.
- Read data valid 2 cycles after first pending cycle in IDLE.
- Write throughput 1 per 2 cycles; read throughput 1 per 3 cycles.
REQ-011 mN_waitrequest SHALL be 1 in every cycle except REQ-008; the losing requester stays stalled until its own ISSUE.
REQ-012 If mN_read and mN_write are both high, the access SHALL be a write.
REQ-013 ram_chipselect and ram_write SHALL be 0 outside ISSUE; ram_address, ram_byteenable and ram_writedata hold their last value.
REQ-014 ram_clken SHALL be 1 at all times except during reset, when it is 0.
REQ-015 mN_readdata SHALL equal ram_readdata in all cycles, qualified only by mN_readdatavalid.
REQ-016 A requester deasserting its command while stalled SHALL simply not be granted; no partial access occurs.
REQ-017 Address is passed through unmodified; no wrap or range check.

Reset
REQ-018 While reset = 1, at each clock edge:
- state <- IDLE.
- last_grant <- 1, so m0 wins the first tie.
- ram_chipselect, ram_write, mN_readdatavalid <- 0.
- mN_waitrequest <- 1.
- ram_address, ram_byteenable, ram_writedata <- 0.
REQ-019 Reset asserted in ISSUE or RDATA SHALL abort the access with no readdatavalid pulse; reset has priority over all transitions.

Verification
REQ-020 m0 write addr 0x0010, data 0xDEADBEEF, be 0xF -> ram_chipselect=ram_write=1 exactly one cycle (ISSUE); m0_waitrequest low that cycle; RAM word 0x0010 = 0xDEADBEEF.
REQ-021 m1 read addr 0x0010 after REQ-020 -> m1_readdatavalid pulses 2 cycles after request, m1_readdata = 0xDEADBEEF; m0_readdatavalid stays 0.
REQ-022 m0 and m1 both write continuously from reset, addresses 0x0001/0x0002 -> grants alternate m0, m1, m0, m1; one ISSUE every 2 cycles.
REQ-023 m0 write be=0x3, data 0x11223344 to word 0x1FFF holding 0xAAAAAAAA; then read -> 0xAAAA3344.
REQ-024 m0 read and write both high, addr 0x0005 -> write performed, no readdatavalid.
REQ-025 Reset pulsed during RDATA of an m1 read -> no m1_readdatavalid; outputs at reset values next cycle; next tie grants m0.
